// File: rtl/uart_rx_param.sv
// Parameterised UART receiver: two-flop synchronised input, 3-sample majority vote
// per bit around the bit midpoint, optional parity and one or two checked stop bits.
module uart_rx_param #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clock100,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 send,
    output logic                 fe,
    output logic                 pe,
    output logic                 busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int MID   = CLKS_PER_BIT / 2;

    localparam logic [CNT_W-1:0] SAMP_A   = CNT_W'(MID - 1);
    localparam logic [CNT_W-1:0] SAMP_B   = CNT_W'(MID);
    localparam logic [CNT_W-1:0] SAMP_C   = CNT_W'(MID + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       IDX_DLAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]       IDX_SLAST = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t               state_q, state_d;
    logic                 rx_s1_q, rx_s2_q, rx_prev_q;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [3:0]           idx_q, idx_d;
    logic [1:0]           samp_q, samp_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 fe_acc_q, fe_acc_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 send_q, send_d;
    logic                 fe_q, fe_d;
    logic                 pe_q, pe_d;

    logic fall;
    logic vote;
    logic at_vote;
    logic at_end;
    logic pe_calc;

    assign fall    = rx_prev_q & ~rx_s2_q;
    assign vote    = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s2_q) | (samp_q[1] & rx_s2_q);
    assign at_vote = (cnt_q == SAMP_C);
    assign at_end  = (cnt_q == CNT_LAST);

    always_comb begin
        pe_calc = 1'b0;
        if (PARITY == 1) begin
            pe_calc = ~(^shift_q ^ par_q);
        end else if (PARITY == 2) begin
            pe_calc = ^shift_q ^ par_q;
        end
    end

    always_ff @(posedge clock100 or posedge reset) begin
        if (reset) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_s1_q   <= rx;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
        end
    end

    always_ff @(posedge clock100 or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            samp_q   <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            fe_acc_q <= 1'b0;
            data_q   <= '0;
            send_q   <= 1'b0;
            fe_q     <= 1'b0;
            pe_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            samp_q   <= samp_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            fe_acc_q <= fe_acc_d;
            data_q   <= data_d;
            send_q   <= send_d;
            fe_q     <= fe_d;
            pe_q     <= pe_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = at_end ? '0 : cnt_q + CNT_W'(1);
        idx_d    = idx_q;
        samp_d   = samp_q;
        shift_d  = shift_q;
        par_d    = par_q;
        fe_acc_d = fe_acc_q;
        data_d   = data_q;
        send_d   = 1'b0;
        fe_d     = fe_q;
        pe_d     = pe_q;

        if (cnt_q == SAMP_A) samp_d[0] = rx_s2_q;
        if (cnt_q == SAMP_B) samp_d[1] = rx_s2_q;

        case (state_q)
            IDLE: begin
                cnt_d    = '0;
                idx_d    = '0;
                fe_acc_d = 1'b0;
                // The detection cycle is bit offset 0, so the counter resumes at 1.
                if (fall) begin
                    state_d = START;
                    cnt_d   = CNT_W'(1);
                end
            end
            START: begin
                if (at_vote && vote) begin
                    state_d = IDLE;
                end else if (at_end) begin
                    state_d = DATA;
                    idx_d   = '0;
                end
            end
            DATA: begin
                if (at_vote) shift_d = {vote, shift_q[DATA_BITS-1:1]};
                if (at_end) begin
                    if (idx_q == IDX_DLAST) begin
                        idx_d   = '0;
                        state_d = (PARITY != 0) ? PAR : STOP;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            PAR: begin
                if (at_vote) par_d = vote;
                if (at_end) begin
                    state_d = STOP;
                    idx_d   = '0;
                end
            end
            STOP: begin
                if (at_vote) begin
                    if (idx_q == IDX_SLAST) begin
                        state_d = IDLE;
                        send_d  = 1'b1;
                        data_d  = shift_q;
                        fe_d    = fe_acc_q | ~vote;
                        pe_d    = pe_calc;
                    end else begin
                        fe_acc_d = fe_acc_q | ~vote;
                    end
                end else if (at_end) begin
                    idx_d = idx_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign data = data_q;
    assign send = send_q;
    assign fe   = fe_q;
    assign pe   = pe_q;
    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: four differently parameterised receivers fed directed and
// random frames, results compared against a frame-level model.
module tb_uart_rx_param;

    localparam int NI = 4;

    logic          clock100 = 1'b0;
    logic          reset    = 1'b1;
    logic [NI-1:0] rx_l     = '1;
    logic [NI-1:0] snd, fe_w, pe_w, busy_w;
    logic [7:0]    d0, d1;
    logic [6:0]    d2;
    logic [4:0]    d3;
    logic [8:0]    dat [NI];

    assign dat[0] = {1'b0, d0};
    assign dat[1] = {1'b0, d1};
    assign dat[2] = {2'b0, d2};
    assign dat[3] = {4'b0, d3};

    always #5 clock100 = ~clock100;

    uart_rx_param u0 (
        .clock100(clock100), .reset(reset), .rx(rx_l[0]), .data(d0),
        .send(snd[0]), .fe(fe_w[0]), .pe(pe_w[0]), .busy(busy_w[0]));

    uart_rx_param #(.PARITY(2), .CLKS_PER_BIT(16)) u1 (
        .clock100(clock100), .reset(reset), .rx(rx_l[1]), .data(d1),
        .send(snd[1]), .fe(fe_w[1]), .pe(pe_w[1]), .busy(busy_w[1]));

    uart_rx_param #(.DATA_BITS(7), .STOP_BITS(2), .CLKS_PER_BIT(16)) u2 (
        .clock100(clock100), .reset(reset), .rx(rx_l[2]), .data(d2),
        .send(snd[2]), .fe(fe_w[2]), .pe(pe_w[2]), .busy(busy_w[2]));

    uart_rx_param #(.DATA_BITS(5), .PARITY(1), .CLKS_PER_BIT(20)) u3 (
        .clock100(clock100), .reset(reset), .rx(rx_l[3]), .data(d3),
        .send(snd[3]), .fe(fe_w[3]), .pe(pe_w[3]), .busy(busy_w[3]));

    function automatic int cfg_cpb(input int i);
        case (i)
            0: return 868;
            3: return 20;
            default: return 16;
        endcase
    endfunction

    function automatic int cfg_nbits(input int i);
        case (i)
            2: return 7;
            3: return 5;
            default: return 8;
        endcase
    endfunction

    function automatic int cfg_par(input int i);
        case (i)
            1: return 2;
            3: return 1;
            default: return 0;
        endcase
    endfunction

    function automatic int cfg_stop(input int i);
        return (i == 2) ? 2 : 1;
    endfunction

    // Frame-level expectation: {pe, fe, data}.
    function automatic logic [10:0] model(input int i, input logic [8:0] d,
                                          input logic p, input logic [1:0] stops);
        logic [8:0] dm;
        int         ones;
        logic       pe_e;
        logic       fe_e;
        dm = '0;
        for (int b = 0; b < cfg_nbits(i); b++) dm[b] = d[b];
        ones = $countones(dm) + int'(p);
        pe_e = 1'b0;
        if (cfg_par(i) == 1) pe_e = (ones % 2 == 0);
        if (cfg_par(i) == 2) pe_e = (ones % 2 == 1);
        fe_e = (stops[0] == 1'b0) || (cfg_stop(i) == 2 && stops[1] == 1'b0);
        return {pe_e, fe_e, dm};
    endfunction

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [10:0] got_q [NI][$];
    logic [10:0] exp_q [NI][$];

    always @(negedge clock100) begin
        for (int i = 0; i < NI; i++) begin
            if (snd[i]) got_q[i].push_back({pe_w[i], fe_w[i], dat[i]});
        end
    end

    task automatic drive_bit(input int i, input logic b);
        rx_l[i] = b;
        repeat (cfg_cpb(i)) @(posedge clock100);
        #1;
    endtask

    task automatic drive_frame(input int i, input logic [8:0] d, input logic p,
                               input logic [1:0] stops);
        drive_bit(i, 1'b0);
        for (int b = 0; b < cfg_nbits(i); b++) drive_bit(i, d[b]);
        if (cfg_par(i) != 0) drive_bit(i, p);
        for (int s = 0; s < cfg_stop(i); s++) drive_bit(i, stops[s]);
    endtask

    task automatic frame_exp(input int i, input logic [8:0] d, input logic p,
                             input logic [1:0] stops);
        exp_q[i].push_back(model(i, d, p, stops));
        drive_frame(i, d, p, stops);
    endtask

    task automatic compare_all(input int i, input string tag);
        logic [10:0] g;
        logic [10:0] e;
        chk({tag, "_count"}, got_q[i].size(), exp_q[i].size());
        while (got_q[i].size() > 0 && exp_q[i].size() > 0) begin
            g = got_q[i].pop_front();
            e = exp_q[i].pop_front();
            $display("u%0d %s: data=0x%0h fe=%0b pe=%0b (want data=0x%0h fe=%0b pe=%0b)",
                     i, tag, g[8:0], g[9], g[10], e[8:0], e[9], e[10]);
            chk(tag, g, e);
        end
        got_q[i].delete();
        exp_q[i].delete();
    endtask

    task automatic idle_bits(input int i, input int n);
        for (int k = 0; k < n; k++) drive_bit(i, 1'b1);
    endtask

    task automatic random_burst(input int i, input int n);
        logic [8:0] d;
        logic       p;
        logic [1:0] stops;
        int         gap;
        for (int k = 0; k < n; k++) begin
            d     = 9'($urandom);
            p     = 1'($urandom_range(0, 1));
            stops = 2'b11;
            if ($urandom_range(0, 7) == 0) stops[0] = 1'b0;
            if ($urandom_range(0, 7) == 0) stops[1] = 1'b0;
            frame_exp(i, d, p, stops);
            gap = $urandom_range(0, 2);
            // A low final stop bit needs an idle-high gap to make the next start edge.
            if (stops[cfg_stop(i) - 1] == 1'b0 && gap == 0) gap = 1;
            idle_bits(i, gap);
        end
        idle_bits(i, 3);
        compare_all(i, "rand");
    endtask

    initial begin
        logic [8:0] ab;
        repeat (3) @(posedge clock100);
        @(negedge clock100);
        chk("rst_data", 32'(d0), 32'h0);
        chk("rst_send", 32'(snd[0]), 32'h0);
        chk("rst_fe", 32'(fe_w[0]), 32'h0);
        chk("rst_pe", 32'(pe_w[0]), 32'h0);
        chk("rst_busy", 32'(busy_w), 32'h0);
        @(posedge clock100);
        #1 reset = 1'b0;
        repeat (10) @(posedge clock100);
        #1;

        // Clean '@' frame on default configuration.
        frame_exp(0, 9'h40, 1'b0, 2'b11);
        idle_bits(0, 2);
        compare_all(0, "f40");
        chk("f40_busy", 32'(busy_w[0]), 32'h0);

        // Framing error, then line held low: exactly one strobe.
        frame_exp(0, 9'h55, 1'b0, 2'b00);
        for (int k = 0; k < 3; k++) drive_bit(0, 1'b0);
        compare_all(0, "f55_fe");
        idle_bits(0, 2);
        chk("f55_nomore", got_q[0].size(), 0);

        // Short low pulse: false start.
        rx_l[0] = 1'b0;
        repeat (10) @(posedge clock100);
        #1 chk("false_busy_hi", 32'(busy_w[0]), 32'h1);
        repeat (290) @(posedge clock100);
        #1 rx_l[0] = 1'b1;
        repeat (2 * 868) @(posedge clock100);
        #1 chk("false_busy_lo", 32'(busy_w[0]), 32'h0);
        compare_all(0, "false_start");

        // Reset in the middle of data bit 4.
        ab = 9'hA5;
        drive_bit(0, 1'b0);
        for (int b = 0; b < 4; b++) drive_bit(0, ab[b]);
        rx_l[0] = ab[4];
        repeat (434) @(posedge clock100);
        #1 chk("abort_busy_pre", 32'(busy_w[0]), 32'h1);
        reset   = 1'b1;
        rx_l[0] = 1'b1;
        @(negedge clock100);
        chk("abort_data", 32'(d0), 32'h0);
        chk("abort_flags", 32'({snd[0], fe_w[0], pe_w[0], busy_w[0]}), 32'h0);
        repeat (5) @(posedge clock100);
        #1 reset = 1'b0;
        idle_bits(0, 2);
        chk("abort_nosend", got_q[0].size(), 0);
        frame_exp(0, 9'h7E, 1'b0, 2'b11);
        idle_bits(0, 2);
        compare_all(0, "f7e");

        // Even parity: 0x41 has two ones.
        frame_exp(1, 9'h41, 1'b1, 2'b11);
        idle_bits(1, 2);
        compare_all(1, "par41_p1");
        frame_exp(1, 9'h41, 1'b0, 2'b11);
        idle_bits(1, 2);
        compare_all(1, "par41_p0");

        // 7N2 back-to-back frames.
        frame_exp(2, 9'h12, 1'b0, 2'b11);
        frame_exp(2, 9'h6D, 1'b0, 2'b11);
        idle_bits(2, 2);
        compare_all(2, "b2b");

        for (int r = 0; r < 2; r++) begin
            random_burst(1, 12);
            random_burst(2, 12);
            random_burst(3, 12);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
